cfg_bus_arbiter: RTL and testbench



---
 rtl/cfg_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_cfg_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter sharing the serial configuration bus between two writers.
// A grant is held until the owner signals DONE, drops REQ, or the watchdog
// expires; every release is followed by a forced idle gap on the bus.
module cfg_bus_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ0,
    input  logic REQ1,
    input  logic DONE0,
    input  logic DONE1,
    input  logic SCLK0,
    input  logic SEL0,
    input  logic MOSI0,
    input  logic SCLK1,
    input  logic SEL1,
    input  logic MOSI1,
    input  logic CLR_ERR,
    output logic GNT0,
    output logic GNT1,
    output logic SCLK_OUT,
    output logic SEL_OUT,
    output logic MOSI_OUT,
    output logic BUSY,
    output logic OWNER,
    output logic TIMEOUT_ERR
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [CW-1:0]   to_cnt_q, to_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            err_q, err_d;
    logic            owner_req, owner_done, set_err;

    // State register; asynchronous reset drops grants and bus immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            owner_q   <= 1'b1;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            owner_q   <= owner_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: arbitration in IDLE, release detection in GRANT, gap timing.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        set_err    = 1'b0;
        owner_req  = owner_q ? REQ1 : REQ0;
        owner_done = owner_q ? DONE1 : DONE0;

        unique case (state_q)
            IDLE: begin
                to_cnt_d  = '0;
                gap_cnt_d = '0;
                if (REQ0 && REQ1) begin
                    owner_d = ~owner_q;
                    state_d = GRANT;
                end else if (REQ0) begin
                    owner_d = 1'b0;
                    state_d = GRANT;
                end else if (REQ1) begin
                    owner_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                to_cnt_d = to_cnt_q + CW'(1);
                if (owner_done || !owner_req) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    set_err   = 1'b1;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A watchdog expiry on the same edge as a clear request keeps the flag set.
        if (set_err)      err_d = 1'b1;
        else if (CLR_ERR) err_d = 1'b0;
        else              err_d = err_q;
    end

    // Bus mux selected only by registered state and owner, so REQ changes cannot glitch it.
    always_comb begin
        SCLK_OUT = 1'b0;
        SEL_OUT  = 1'b0;
        MOSI_OUT = 1'b0;
        if (state_q == GRANT) begin
            SCLK_OUT = owner_q ? SCLK1 : SCLK0;
            SEL_OUT  = owner_q ? SEL1  : SEL0;
            MOSI_OUT = owner_q ? MOSI1 : MOSI0;
        end
    end

    assign GNT0        = (state_q == GRANT) && !owner_q;
    assign GNT1        = (state_q == GRANT) &&  owner_q;
    assign BUSY        = (state_q != IDLE);
    assign OWNER       = owner_q;
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Bench for cfg_bus_arbiter: directed scenarios with literal expectations plus
// a cycle-level behavioural model compared on every falling clock edge.
module tb_cfg_bus_arbiter;

    localparam int GAP = 4;
    localparam int TO  = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic REQ0 = 0, REQ1 = 0, DONE0 = 0, DONE1 = 0, CLR_ERR = 0;
    logic SCLK0 = 0, SEL0 = 0, MOSI0 = 0, SCLK1 = 0, SEL1 = 0, MOSI1 = 0;
    logic GNT0, GNT1, SCLK_OUT, SEL_OUT, MOSI_OUT, BUSY, OWNER, TIMEOUT_ERR;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 0;

    cfg_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .DONE0(DONE0), .DONE1(DONE1),
        .SCLK0(SCLK0), .SEL0(SEL0), .MOSI0(MOSI0),
        .SCLK1(SCLK1), .SEL1(SEL1), .MOSI1(MOSI1),
        .CLR_ERR(CLR_ERR),
        .GNT0(GNT0), .GNT1(GNT1),
        .SCLK_OUT(SCLK_OUT), .SEL_OUT(SEL_OUT), .MOSI_OUT(MOSI_OUT),
        .BUSY(BUSY), .OWNER(OWNER), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    // Wait (bounded) for any grant; reports edges waited and gap-state cycles seen.
    task automatic wait_gnt(output int n, output int g);
        n = 0;
        g = 0;
        while (!(GNT0 || GNT1) && n < 64) begin
            if (BUSY) g++;
            tick(1);
            n++;
        end
        check("wait_gnt_bound", 32'(n < 64), 1);
    endtask

    // Behavioural model: who holds the bus, for how long, and how much gap remains.
    int m_gnt   = -1;   // granted requester, -1 when nobody holds the bus
    int m_age   = 0;    // cycles the current grant has been held
    int m_gap   = 0;    // forced idle cycles still to go
    bit m_owner = 1'b1;
    bit m_err   = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_gnt = -1; m_age = 0; m_gap = 0; m_owner = 1'b1; m_err = 1'b0;
        end else begin
            bit set_e, rq, dn;
            set_e = 1'b0;
            if (m_gnt >= 0) begin
                m_age++;
                rq = (m_gnt == 0) ? REQ0 : REQ1;
                dn = (m_gnt == 0) ? DONE0 : DONE1;
                if (dn || !rq) begin
                    m_gnt = -1; m_gap = GAP;
                end else if (m_age == TO) begin
                    m_gnt = -1; m_gap = GAP; set_e = 1'b1;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (REQ0 || REQ1) begin
                if (REQ0 && REQ1) m_owner = !m_owner;
                else              m_owner = REQ1;
                m_gnt = m_owner ? 1 : 0;
                m_age = 0;
            end
            if (set_e)        m_err = 1'b1;
            else if (CLR_ERR) m_err = 1'b0;
        end
    end

    // Compare DUT against the model every falling edge.
    logic e_sclk, e_sel, e_mosi;
    always @(negedge CLK) begin
        if (chk_en) begin
            {e_sclk, e_sel, e_mosi} = 3'b000;
            if (m_gnt == 0) {e_sclk, e_sel, e_mosi} = {SCLK0, SEL0, MOSI0};
            if (m_gnt == 1) {e_sclk, e_sel, e_mosi} = {SCLK1, SEL1, MOSI1};
            check("model_gnt0", GNT0, 32'(m_gnt == 0));
            check("model_gnt1", GNT1, 32'(m_gnt == 1));
            check("model_busy", BUSY, 32'(m_gnt >= 0 || m_gap > 0));
            check("model_owner", OWNER, m_owner);
            check("model_err", TIMEOUT_ERR, m_err);
            check("model_sclk", SCLK_OUT, e_sclk);
            check("model_sel", SEL_OUT, e_sel);
            check("model_mosi", MOSI_OUT, e_mosi);
            check("no_overlap", GNT0 & GNT1, 0);
        end
    end

    logic [31:0] rnd;

    initial begin
        int n, g;

        // Reset values, single requester, mux routing.
        tick(2);
        chk_en = 1;
        check("rst_gnt0", GNT0, 0);
        check("rst_gnt1", GNT1, 0);
        check("rst_busy", BUSY, 0);
        check("rst_owner", OWNER, 1);
        check("rst_err", TIMEOUT_ERR, 0);
        check("rst_sel", SEL_OUT, 0);
        RST = 0;
        tick(1);
        REQ0 = 1;
        tick(1);
        check("req0_gnt0", GNT0, 1);
        check("req0_gnt1", GNT1, 0);
        check("req0_owner", OWNER, 0);
        SCLK0 = 1; SCLK1 = 0; SEL0 = 1; SEL1 = 0;
        #1 check("sclk_follow_hi", SCLK_OUT, 1);
        check("sel_follow", SEL_OUT, 1);
        SCLK0 = 0; SCLK1 = 1;
        #1 check("sclk_follow_lo", SCLK_OUT, 0);
        for (int k = 0; k < 6; k++) begin
            SCLK0 = k[0]; SCLK1 = ~k[0]; MOSI1 = 1; MOSI0 = k[1];
            tick(1);
        end
        SCLK0 = 1; DONE0 = 1; REQ0 = 0;
        tick(1);
        DONE0 = 0;
        check("rel_gnt0", GNT0, 0);
        check("rel_busy", BUSY, 1);
        check("rel_sclk", SCLK_OUT, 0);
        SCLK0 = 0; SEL0 = 0; MOSI0 = 0; SCLK1 = 0; MOSI1 = 0;
        tick(6);

        // Round robin from reset: 0,1,0,1 with 4 gap cycles and 5-edge turnaround.
        RST = 1;
        tick(1);
        RST = 0;
        check("rr_rst_owner", OWNER, 1);
        REQ0 = 1; REQ1 = 1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n, g);
            check("rr_order", GNT1, k % 2);
            if (k > 0) begin
                check("rr_turnaround", n, GAP + 1);
                check("rr_gap_len", g, GAP);
            end
            for (int c = 0; c < 9; c++) begin
                rnd = $urandom;
                {SCLK0, SEL0, MOSI0, SCLK1, SEL1, MOSI1} = rnd[5:0];
                tick(1);
            end
            if (GNT1) DONE1 = 1; else DONE0 = 1;
            tick(1);
            DONE0 = 0; DONE1 = 0;
            rnd = $urandom;
            {SCLK0, SEL0, MOSI0, SCLK1, SEL1, MOSI1} = rnd[5:0];
            check("rr_release", GNT0 | GNT1, 0);
        end
        REQ0 = 0; REQ1 = 0;
        {SCLK0, SEL0, MOSI0, SCLK1, SEL1, MOSI1} = 6'b0;
        tick(6);

        // Watchdog expiry, with CLR_ERR on the same edge (set wins).
        REQ1 = 1;
        wait_gnt(n, g);
        check("to_gnt1", GNT1, 1);
        n = 0;
        while (GNT1 && n < 64) begin
            if (n == TO - 1) CLR_ERR = 1;
            tick(1);
            CLR_ERR = 0;
            n++;
        end
        check("to_hold_len", n, TO);
        check("to_err_set", TIMEOUT_ERR, 1);
        check("to_busy_gap", BUSY, 1);
        wait_gnt(n, g);
        check("to_regrant", GNT1, 1);
        check("to_regrant_turn", n, GAP + 1);
        check("to_err_held", TIMEOUT_ERR, 1);
        CLR_ERR = 1;
        tick(1);
        CLR_ERR = 0;
        check("to_err_clr", TIMEOUT_ERR, 0);
        REQ1 = 0;
        tick(1);
        check("req_drop_rel", GNT1, 0);
        tick(6);

        // DONE coincident with the timeout edge: normal release, no error.
        REQ1 = 1;
        wait_gnt(n, g);
        tick(TO - 1);
        check("tod_still_gnt", GNT1, 1);
        DONE1 = 1;
        tick(1);
        DONE1 = 0; REQ1 = 0;
        check("tod_rel", GNT1, 0);
        check("tod_err", TIMEOUT_ERR, 0);
        tick(6);

        // Asynchronous reset mid-grant, then tie goes to requester 0.
        REQ1 = 1;
        wait_gnt(n, g);
        SEL1 = 1;
        tick(2);
        #1 check("arst_sel_before", SEL_OUT, 1);
        RST = 1;
        #1 check("arst_sel", SEL_OUT, 0);
        check("arst_gnt1", GNT1, 0);
        check("arst_busy", BUSY, 0);
        tick(1);
        RST = 0; REQ0 = 1; REQ1 = 1;
        tick(1);
        check("arst_tie_gnt0", GNT0, 1);
        check("arst_tie_gnt1", GNT1, 0);
        check("arst_tie_owner", OWNER, 0);
        REQ0 = 0; REQ1 = 0; SEL1 = 0;
        tick(7);

        // Non-owner DONE ignored; DONE during GAP ignored; gap still 4.
        REQ1 = 1;
        wait_gnt(n, g);
        tick(2);
        DONE0 = 1;
        tick(1);
        DONE0 = 0;
        check("nonowner_done", GNT1, 1);
        DONE1 = 1;
        tick(1);
        DONE1 = 0;
        check("own_done_rel", GNT1, 0);
        n = 0; g = 0;
        while (!(GNT0 || GNT1) && n < 64) begin
            if (BUSY) g++;
            if (n == 1) DONE1 = 1;
            tick(1);
            DONE1 = 0;
            n++;
        end
        check("gapdone_gap_len", g, GAP);
        check("gapdone_turn", n, GAP + 1);
        check("gapdone_regrant", GNT1, 1);
        REQ1 = 0;
        tick(1);
        check("final_rel", GNT1, 0);
        tick(6);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
